// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states, register offsets and STATUS bit positions for the MMIO UART TX
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [2:0] TXDATA_OFF = 3'd0;
  localparam logic [2:0] STATUS_OFF = 3'd4;

  localparam int FULL      = 0;
  localparam int EMPTY     = 1;
  localparam int BUSY      = 2;
  localparam int OVF       = 3;
  localparam int COUNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; a push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // DEPTH is a power of two, so the count MSB alone marks full
  assign full     = count[AW];
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - MMIO 8N1 UART transmitter with TX FIFO; define UART_TX_SIM_PRINT_EN to echo accepted bytes with $write
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [31:0]   off;
  logic [2:0]    word_off;
  logic          is_txdata;
  logic          is_status;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   count;
  logic [7:0]    fifo_data;
  logic [7:0]    shift;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          bit_end;
  logic          ovf;
  logic [31:0]   status;
  uart_state_e   state;
  logic          unused_bits;

  assign hit       = (addr >= BASE_ADDR) && (addr <= BASE_ADDR + 32'd7);
  assign off       = addr - BASE_ADDR;
  assign word_off  = {off[2], 2'b00};
  assign is_txdata = (word_off == TXDATA_OFF);
  assign is_status = (word_off == STATUS_OFF);
  assign bit_end   = (baud_cnt == '0);
  assign push      = we && hit && is_txdata;
  // The FIFO is drained either from IDLE or back-to-back at the end of a stop bit
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign unused_bits = ^{wdata[31:8], off[31:3], off[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wdata[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_comb begin
    status                  = '0;
    status[FULL]            = fifo_full;
    status[EMPTY]           = fifo_empty;
    status[BUSY]            = (state != IDLE);
    status[OVF]             = ovf;
    status[COUNT_LSB +: 4]  = 4'(count);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf   <= 1'b0;
      rdata <= '0;
    end else begin
      if (push && fifo_full && !pop) begin
        ovf <= 1'b1;
      end else if (we && hit && is_status && wdata[OVF]) begin
        ovf <= 1'b0;
      end
      if (re && hit) begin
        rdata <= is_status ? status : 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= fifo_data;
            tx       <= 1'b0;
            baud_cnt <= BIT_LAST;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx       <= shift[0];
            bit_idx  <= '0;
            baud_cnt <= BIT_LAST;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift    <= fifo_data;
              tx       <= 1'b0;
              baud_cnt <= BIT_LAST;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_SIM_PRINT_EN
  always_ff @(posedge clk) begin
    if (reset && push && (!fifo_full || pop)) begin
      $write("%c", wdata[7:0]);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx against a frame-level line model
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        hit;
  logic        tx;
  logic [31:0] rdata;

  int tests_run = 0;
  int fails = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .hit   (hit),
    .rdata (rdata),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_hit(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd7);
  endfunction

  // Line model: bytes waiting, plus the per-cycle samples of the frame on the wire
  byte unsigned mq[$];
  logic         wave_q[$];
  logic         ovf_m = 1'b0;
  logic         active_m = 1'b0;
  logic         tx_m = 1'b1;
  logic [31:0]  rdata_m = '0;
  logic         model_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [31:0]  st;
    logic [31:0]  off;
    logic         h;
    logic         bv;
    byte unsigned b;
    if (!reset) begin
      mq.delete();
      wave_q.delete();
      ovf_m = 1'b0;
      active_m = 1'b0;
      tx_m = 1'b1;
      rdata_m = '0;
      model_valid = 1'b1;
    end else begin
      h   = exp_hit(addr);
      off = addr - BASE;
      st  = (32'(mq.size()) << 4) | (32'(ovf_m) << 3) | (32'(active_m) << 2)
          | (32'(mq.size() == 0) << 1) | 32'(mq.size() == DEPTH);
      if (re && h) rdata_m = off[2] ? st : 32'd0;
      if (wave_q.size() == 0) begin
        if (mq.size() > 0) begin
          b = mq.pop_front();
          for (int bi = 0; bi < 10; bi++) begin
            bv = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
            repeat (CPB) wave_q.push_back(bv);
          end
          active_m = 1'b1;
        end else begin
          active_m = 1'b0;
        end
      end
      tx_m = (wave_q.size() > 0) ? wave_q.pop_front() : 1'b1;
      if (we && h && !off[2]) begin
        if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
        else ovf_m = 1'b1;
      end
      if (we && h && off[2] && wdata[3]) ovf_m = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_tx", {31'b0, tx}, {31'b0, tx_m});
      check("model_rdata", rdata, rdata_m);
      check("model_hit", {31'b0, hit}, {31'b0, exp_hit(addr)});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    addr = a;
    re = 1'b1;
    @(posedge clk);
    #1;
    re = 1'b0;
  endtask

  initial begin
    logic [9:0] seq;

    idle(2);
    check("t1_reset_tx", {31'b0, tx}, 32'd1);
    check("t1_reset_rdata", rdata, 32'd0);
    reset = 1'b1;
    load(BASE + 32'd4);
    check("t1_status", rdata, 32'h0000_0002);

    store(BASE, 32'h55);
    seq = 10'b1010101010;
    for (int k = 1; k <= 40; k++) begin
      idle(1);
      check("t2_frame", {31'b0, tx}, {31'b0, seq[(k-1)/CPB]});
    end
    idle(1);
    load(BASE + 32'd4);
    check("t2_not_busy", rdata, 32'h0000_0002);

    for (int i = 0; i < 6; i++) store(BASE, 32'h41 + i);
    load(BASE + 32'd4);
    check("t3_status_full", rdata, 32'h0000_004D);
    store(BASE + 32'd4, 32'h8);
    load(BASE + 32'd4);
    check("t3_ovf_bit", rdata & 32'h8, 32'd0);
    check("t3_status_clr", rdata, 32'h0000_0045);
    idle(210);

    store(BASE, 32'hA5);
    store(BASE, 32'h3C);
    idle(35);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check("t4_stop_bit", {31'b0, tx}, 32'd1);
    end
    idle(1);
    check("t4_no_gap_start", {31'b0, tx}, 32'd0);
    load(BASE + 32'd4);
    check("t4_status_busy", rdata, 32'h0000_0006);
    idle(60);

    store(BASE, 32'h11);
    store(BASE, 32'h22);
    store(BASE, 32'h33);
    idle(15);
    check("t5_data_bit3", {31'b0, tx}, 32'd0);
    reset = 1'b0;
    idle(1);
    check("t5_reset_tx", {31'b0, tx}, 32'd1);
    check("t5_reset_rdata", rdata, 32'd0);
    reset = 1'b1;
    load(BASE + 32'd4);
    check("t5_status", rdata, 32'h0000_0002);
    idle(50);
    check("t5_line_idle", {31'b0, tx}, 32'd1);

    addr = BASE + 32'd8;
    wdata = 32'h77;
    we = 1'b1;
    #1;
    check("t6_hit_above", {31'b0, hit}, 32'd0);
    @(posedge clk);
    #1;
    we = 1'b0;
    addr = BASE - 32'd4;
    re = 1'b1;
    #1;
    check("t6_hit_below", {31'b0, hit}, 32'd0);
    @(posedge clk);
    #1;
    re = 1'b0;
    check("t6_rdata_hold", rdata, 32'h0000_0002);
    addr = BASE + 32'd7;
    #1;
    check("t6_hit_top", {31'b0, hit}, 32'd1);
    addr = BASE - 32'd1;
    #1;
    check("t6_hit_under", {31'b0, hit}, 32'd0);
    idle(10);
    check("t6_tx_idle", {31'b0, tx}, 32'd1);
    load(BASE + 32'd4);
    check("t6_no_push", rdata, 32'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
